// File: rtl/bla_pkg.sv
// Shared definitions for the borrow-lookahead subtract pipeline: slice width,
// stage count helper and the per-slice result record.
package bla_pkg;

  localparam int SLICE_W = 4;

  function automatic int stage_count(input int width);
    return width / SLICE_W;
  endfunction

  typedef struct packed {
    logic [SLICE_W-1:0] diff;
    logic               borrow;
  } slice_res_t;

endpackage

// File: rtl/bla_slice4.sv
// Combinational 4-bit borrow-lookahead subtract slice: diff = a - b - bin,
// borrow out set when a < b + bin.
module bla_slice4
  import bla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output slice_res_t         res
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
  always_comb begin
    g    = ~a & b;
    p    = ~(a ^ b);
    c[0] = bin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    res.diff   = a ^ b ^ c[SLICE_W-1:0];
    res.borrow = c[SLICE_W];
  end

endmodule

// File: rtl/bla_sub_pipe.sv
// Pipelined WIDTH-bit subtractor, one 4-bit borrow-lookahead slice per stage,
// valid/ready on both sides. Define BLA_SUB_OVF_EN to add the signed Ovf output.
module bla_sub_pipe
  import bla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef BLA_SUB_OVF_EN
  ,output logic            Ovf
`endif
);

  localparam int N = stage_count(WIDTH);

  logic [WIDTH-1:0] src_a    [N];
  logic [WIDTH-1:0] src_b    [N];
  logic [WIDTH-1:0] src_diff [N];
  logic             src_borrow [N];
  slice_res_t       slice_res  [N];

  logic [WIDTH-1:0] a_d [N], a_q [N];
  logic [WIDTH-1:0] b_d [N], b_q [N];
  logic [WIDTH-1:0] diff_d [N], diff_q [N];
  logic             borrow_d [N], borrow_q [N];
  logic             valid_d [N], valid_q [N];

  logic advance;

  assign advance   = ~valid_q[N-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[N-1];
  assign D         = diff_q[N-1];
  assign Bout      = borrow_q[N-1];

  for (genvar k = 0; k < N; k++) begin : g_slice
    bla_slice4 u_slice (
      .a   (src_a[k][SLICE_W*k +: SLICE_W]),
      .b   (src_b[k][SLICE_W*k +: SLICE_W]),
      .bin (src_borrow[k]),
      .res (slice_res[k])
    );
  end

  // Operands travel whole (skew) and finished slices accumulate in diff (deskew).
  always_comb begin
    for (int k = 0; k < N; k++) begin
      int prev;
      prev = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        src_a[k]      = A;
        src_b[k]      = B;
        src_borrow[k] = Bin;
        src_diff[k]   = '0;
        valid_d[k]    = in_valid;
      end else begin
        src_a[k]      = a_q[prev];
        src_b[k]      = b_q[prev];
        src_borrow[k] = borrow_q[prev];
        src_diff[k]   = diff_q[prev];
        valid_d[k]    = valid_q[prev];
      end
      a_d[k]      = src_a[k];
      b_d[k]      = src_b[k];
      diff_d[k]   = src_diff[k];
      diff_d[k][SLICE_W*k +: SLICE_W] = slice_res[k].diff;
      borrow_d[k] = slice_res[k].borrow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        a_q[k]      <= '0;
        b_q[k]      <= '0;
        diff_q[k]   <= '0;
        borrow_q[k] <= 1'b0;
        valid_q[k]  <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < N; k++) begin
        a_q[k]      <= a_d[k];
        b_q[k]      <= b_d[k];
        diff_q[k]   <= diff_d[k];
        borrow_q[k] <= borrow_d[k];
        valid_q[k]  <= valid_d[k];
      end
    end
  end

`ifdef BLA_SUB_OVF_EN
  logic ovf_d, ovf_q;

  // Overflow only when operand signs differ and the result sign leaves A's.
  always_comb begin
    ovf_d = (src_a[N-1][WIDTH-1] ^ src_b[N-1][WIDTH-1])
          & (diff_d[N-1][WIDTH-1] ^ src_a[N-1][WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule
